fp16pipe_arb: RTL and testbench
===============================

Name: fp16pipe_arb

Overview:
- Round-robin arbiter that shares one fixed-latency fp16 pipelined unit (add/mul variants with ports clk, rst_n, i_a, i_b, o_res) between N_REQ requesters.
- Accepts at most one operand pair per cycle and registers it into the pipe.
- Tracks each in-flight operation with a tag shift register of depth LATENCY, then steers the pipe result back to the originating requester.
- The fp16 unit has no valid/stall; this block supplies all sequencing.

Parameters:
N_REQ, 4, number of requesters (2..8)
LATENCY, 3, cycles from pipe i_a/i_b change to o_res (must match instantiated fp16pipe unit, >=1)

Ports:
clk  input  1  clock, all logic on posedge
rst_n  input  1  reset, synchronous, active-low
i_en  input  1  1 = new grants allowed; 0 = no new accepts, in-flight ops still drain
i_req_valid  input  N_REQ  per-requester operation request
o_req_ready  output  N_REQ  one-hot grant; accept = valid & ready
i_req_a  input  16*N_REQ  operand a, requester r at [16r+15:16r]
i_req_b  input  16*N_REQ  operand b, same packing
o_rsp_valid  output  N_REQ  one-hot result strobe, one cycle, no backpressure
o_rsp_res  output  16  result, valid when any o_rsp_valid bit set
o_pipe_a  output  16  to fp16 unit i_a
o_pipe_b  output  16  to fp16 unit i_b
i_pipe_res  input  16  from fp16 unit o_res
o_inflight  output  $clog2(LATENCY+2)  number of accepted, not yet returned ops
o_busy  output  1  o_inflight != 0

Behaviour:
- Reset (rst_n=0 at posedge): RR pointer=0; issue register, tag valids, and tags cleared; o_pipe_a/o_pipe_b=16'h0000; o_rsp_valid=0; o_rsp_res=0; o_inflight=0; o_busy=0. In-flight ops are discarded. Reset mid-stream: no rsp_valid for any op accepted before reset, even though the pipe still holds data.
- Arbitration (combinational):
  - Search i_req_valid starting at pointer p, wrapping modulo N_REQ. The first set bit gets o_req_ready.
  - o_req_ready=0 when i_en=0, rst_n=0, or no request.
  - Ready is never asserted to a non-requesting port.
- Pointer update: on accept by requester g, p <= (g+1) mod N_REQ. No accept leaves p unchanged.
- Issue stage (registered): on accept at edge k, o_pipe_a/o_pipe_b <= granted operands at edge k, and tag stage 0 <= {valid=1, id=g}.
  - Without accept, tag stage 0 valid <= 0 and o_pipe_a/b <= 16'h0000, so the idle pipe sees zeros.
- Tag pipe: LATENCY+1 stages total (issue + LATENCY), shifting every cycle. No stall exists.
- Response: o_rsp_valid[id] = valid of the last tag stage; o_rsp_res = i_pipe_res when valid, else 16'h0000 (combinational from i_pipe_res).
  - An op accepted at edge k has o_rsp_valid high during the cycle after edge k+LATENCY, i.e. it is sampled by the requester at edge k+LATENCY+1.
  - Total accept-to-sample latency is LATENCY+1.
- Throughput: 1 op/cycle sustained. Results return in accept order.
  - Same-requester back-to-back accepts are possible only when it is the sole requester.
- o_inflight: +1 on accept, -1 on the response cycle. Both in the same cycle leave it unchanged. Max value LATENCY+1.
- i_en deassert: current cycle's ready drops immediately. Already-accepted ops complete and return normally.
- Operands unchanged: the block never modifies data. NaN, Inf, and denormal handling belongs to the fp16 unit.

Test Plan:
- Single op, N_REQ=4, LATENCY=3, add unit: req1 a=3C00 b=4000 at edge 10 -> ready[1]=1, o_pipe_a/b=3C00/4000 after edge 10, o_rsp_valid=0010 with o_rsp_res=4200 sampled at edge 14; o_inflight 1 during edges 11-14, then 0.
- All four requesting continuously from p=0 -> grants 0,1,2,3,0,1 on consecutive cycles; responses in the same order, each LATENCY+1 after its accept; o_inflight saturates at 4.
- Requesters 0 and 2 only, p=1 -> grant order 2,0,2,0; requester 0 ops 3C00+3C00 give 4000, requester 2 ops 4000+4000 give 4400, with no cross-routing.
- i_en=0 for 3 cycles while 2 ops in flight -> no ready, both results return on schedule, o_busy falls to 0, then grants resume from the stored pointer.
- Reset asserted 2 cycles after 3 accepts -> no o_rsp_valid pulses afterward, o_inflight=0, o_pipe_a/b=0000, pointer=0 (first grant goes to lowest requesting index).
- Same-cycle accept and response (steady stream) -> o_inflight constant; each response value checked against a reference model per requester id.

Source files
------------

// File: rtl/fp16pipe_arb.sv
// fp16pipe_arb
//   Round-robin front end for one fixed-latency fp16 pipelined unit.
//   At most one operand pair is accepted per cycle. The winner's operands are
//   registered into the pipe, and a tag {valid,id} travels alongside them.
//   When the tag reaches the end of the pipe, the unit's result is strobed back
//   to the requester that issued it. The fp16 unit has no handshake, so every
//   bit of sequencing lives here.
//
// Ports
//   clk, rst_n        clock (posedge) and synchronous active-low reset
//   i_en              1 = grants allowed; 0 = no new accepts, in-flight ops drain
//   i_req_valid       per-requester request
//   o_req_ready       one-hot grant (accept = valid & ready)
//   i_req_a/i_req_b   operands, requester r at [16r+15:16r]
//   o_rsp_valid       one-hot, single-cycle result strobe
//   o_rsp_res         result; zero unless a strobe is active
//   o_pipe_a/o_pipe_b operands to the fp16 unit (zero when idle)
//   i_pipe_res        result from the fp16 unit
//   o_inflight        accepted ops not yet returned
//   o_busy            o_inflight != 0

// One response lane per requester. It decodes the tag at the pipe exit into
// that requester's strobe.
module fp16pipe_arb_lane #(
    parameter int PW = 2,
    parameter int ID = 0
) (
    input  logic          rsp_vld,
    input  logic [PW-1:0] rsp_id,
    output logic          strobe
);
    assign strobe = rsp_vld && (rsp_id == PW'(ID));
endmodule

module fp16pipe_arb #(
    parameter int N_REQ   = 4,
    parameter int LATENCY = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_en,
    input  logic [N_REQ-1:0]             i_req_valid,
    output logic [N_REQ-1:0]             o_req_ready,
    input  logic [16*N_REQ-1:0]          i_req_a,
    input  logic [16*N_REQ-1:0]          i_req_b,
    output logic [N_REQ-1:0]             o_rsp_valid,
    output logic [15:0]                  o_rsp_res,
    output logic [15:0]                  o_pipe_a,
    output logic [15:0]                  o_pipe_b,
    input  logic [15:0]                  i_pipe_res,
    output logic [$clog2(LATENCY+2)-1:0] o_inflight,
    output logic                         o_busy
);
    localparam int PW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW     = $clog2(LATENCY+2);
    localparam int STAGES = LATENCY;    // tag stage 0 = issue, STAGES = pipe exit

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
    } operands_t;

    logic [PW-1:0]             ptr;
    logic [PW-1:0]             gnt_id;
    logic                      gnt_any;
    logic                      accept;
    logic [N_REQ-1:0]          ready;
    operands_t                 gnt_ops;

    logic [STAGES:0]           vld_pipe;
    logic [STAGES:0][PW-1:0]   id_pipe;
    logic [CW-1:0]             inflight;

    // Rotating priority search. The first valid request at or after ptr wins,
    // wrapping modulo N_REQ.
    always_comb begin
        int            idx;
        logic [PW-1:0] cand;
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        cand    = '0;
        for (int d = 0; d < N_REQ; d++) begin
            idx = int'(ptr) + d;
            if (idx >= N_REQ) idx = idx - N_REQ;
            cand = PW'(idx);
            if (!gnt_any && i_req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_id  = cand;
            end
        end
    end

    // Ready is also held off during reset. This keeps an accept from being
    // counted on the edge that clears the tag pipe.
    always_comb begin
        ready = '0;
        if (rst_n && i_en && gnt_any) ready[gnt_id] = 1'b1;
    end

    assign o_req_ready = ready;
    assign accept      = |(ready & i_req_valid);
    assign gnt_ops.a   = i_req_a[16*gnt_id +: 16];
    assign gnt_ops.b   = i_req_b[16*gnt_id +: 16];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr      <= '0;
            o_pipe_a <= '0;
            o_pipe_b <= '0;
            vld_pipe <= '0;
            id_pipe  <= '0;
            inflight <= '0;
        end else begin
            if (accept) ptr <= (gnt_id == PW'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
            // An idle cycle drives zeros, so the unit never sees stale operands.
            o_pipe_a <= accept ? gnt_ops.a : 16'h0000;
            o_pipe_b <= accept ? gnt_ops.b : 16'h0000;
            vld_pipe <= {vld_pipe[STAGES-1:0], accept};
            id_pipe  <= {id_pipe[STAGES-1:0], gnt_id};
            // An accept and a retire in the same cycle cancel out.
            inflight <= inflight + CW'(accept) - CW'(vld_pipe[STAGES]);
        end
    end

    for (genvar r = 0; r < N_REQ; r++) begin : g_lane
        fp16pipe_arb_lane #(.PW(PW), .ID(r)) u_lane (
            .rsp_vld (vld_pipe[STAGES]),
            .rsp_id  (id_pipe[STAGES]),
            .strobe  (o_rsp_valid[r])
        );
    end

    assign o_rsp_res  = vld_pipe[STAGES] ? i_pipe_res : 16'h0000;
    assign o_inflight = inflight;
    assign o_busy     = (inflight != '0);
endmodule

// File: tb/tb_fp16pipe_arb.sv
// Bench for fp16pipe_arb (N_REQ=4, LATENCY=3). The fp16 unit stand-in is a
// LATENCY-deep adder for integer-valued fp16 numbers. A negedge monitor
// compares every output, every cycle, against a queue-based reference model.
module tb_fp16pipe_arb;
    localparam int N  = 4;
    localparam int L  = 3;
    localparam int NW = $clog2(N);
    localparam int CW = $clog2(L+2);

    logic clk = 1'b0;
    logic rst_n, en;
    logic [N-1:0]    req_valid, req_ready, rsp_valid;
    logic [16*N-1:0] req_a, req_b;
    logic [15:0]     rsp_res, pipe_a, pipe_b, pipe_res;
    logic [CW-1:0]   inflight;
    logic            busy;

    int tests = 0;
    int fails = 0;
    int ncnt  = 0;
    int ax [N];
    int bx [N];

    always #5 clk = ~clk;
    always @(posedge clk) ncnt <= ncnt + 1;

    fp16pipe_arb #(.N_REQ(N), .LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n), .i_en(en),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_a(req_a), .i_req_b(req_b),
        .o_rsp_valid(rsp_valid), .o_rsp_res(rsp_res),
        .o_pipe_a(pipe_a), .o_pipe_b(pipe_b), .i_pipe_res(pipe_res),
        .o_inflight(inflight), .o_busy(busy)
    );

    // Integer-valued fp16 helpers. Valid for values 0..2047.
    function automatic logic [15:0] enc(input int n);
        int e;
        logic [15:0] h;
        if (n <= 0) return 16'h0000;
        e = 0;
        while ((n >> (e+1)) != 0) e++;
        h[15]    = 1'b0;
        h[14:10] = 5'(e + 15);
        h[9:0]   = 10'((n << (10 - e)) & 1023);
        return h;
    endfunction

    function automatic int dec(input logic [15:0] h);
        int e, v;
        e = int'(h[14:10]);
        if (e == 0) return 0;
        v = 1024 + int'(h[9:0]);
        if (e >= 25) return v << (e - 25);
        return v >> (25 - e);
    endfunction

    // fp16 unit stand-in: L register stages from i_a/i_b to o_res.
    logic [15:0] pst [L];
    always @(posedge clk) begin
        pst[0] <= enc(dec(pipe_a) + dec(pipe_b));
        for (int i = 1; i < L; i++) pst[i] <= pst[i-1];
    end
    assign pipe_res = pst[L-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, ncnt);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int k;      // accept edge
        int id;
        int x;
        int y;
    } op_t;
    op_t ops[$];
    int  p_m = 0;
    int  n_m, g_m, cnt_m, r_m;
    logic found_m;
    logic [N-1:0]  exp_rdy, exp_rv;
    logic [15:0]   exp_pa, exp_pb, exp_res;

    always @(negedge clk) begin
        n_m = ncnt;   // edges completed so far
        exp_rdy = '0;
        found_m = 1'b0;
        g_m = 0;
        if (rst_n && en) begin
            for (int d = 0; d < N; d++) begin
                r_m = (p_m + d) % N;
                if (!found_m && req_valid[NW'(r_m)]) begin
                    found_m = 1'b1;
                    g_m = r_m;
                    exp_rdy[NW'(r_m)] = 1'b1;
                end
            end
        end
        exp_pa = '0; exp_pb = '0; exp_rv = '0; exp_res = '0; cnt_m = 0;
        foreach (ops[i]) begin
            if (ops[i].k == n_m) begin
                exp_pa = enc(ops[i].x);
                exp_pb = enc(ops[i].y);
            end
            if (ops[i].k == n_m - L) begin
                exp_rv[NW'(ops[i].id)] = 1'b1;
                exp_res = enc(ops[i].x + ops[i].y);
            end
            if (ops[i].k <= n_m && n_m <= ops[i].k + L) cnt_m++;
        end
        chk("ready",     req_ready, exp_rdy);
        chk("pipe_a",    pipe_a,    exp_pa);
        chk("pipe_b",    pipe_b,    exp_pb);
        chk("rsp_valid", rsp_valid, exp_rv);
        chk("rsp_res",   rsp_res,   exp_res);
        chk("inflight",  inflight,  cnt_m);
        chk("busy",      busy,      cnt_m != 0);
        // Apply the outcome of the coming edge.
        if (!rst_n) begin
            ops.delete();
            p_m = 0;
        end else if (found_m) begin
            ops.push_back('{n_m + 1, g_m, ax[g_m], bx[g_m]});
            p_m = (g_m + 1) % N;
        end
        while (ops.size() > 0 && ops[0].k < n_m - L) void'(ops.pop_front());
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input int x, input int y);
        ax[r] = x;
        bx[r] = y;
        req_a[16*r +: 16] = enc(x);
        req_b[16*r +: 16] = enc(y);
        req_valid[NW'(r)] = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    typedef struct {
        int          r;
        int          x;
        int          y;
        logic [15:0] ea;
        logic [15:0] eb;
        logic [15:0] eres;
    } vec_t;
    vec_t tbl [5];

    initial begin
        tbl[0] = '{1,   1,  2, 16'h3C00, 16'h4000, 16'h4200};
        tbl[1] = '{0,   1,  1, 16'h3C00, 16'h3C00, 16'h4000};
        tbl[2] = '{2,   2,  2, 16'h4000, 16'h4000, 16'h4400};
        tbl[3] = '{3,   5,  3, 16'h4500, 16'h4200, 16'h4800};
        tbl[4] = '{0, 100, 28, 16'h5640, 16'h4F00, 16'h5800};
        for (int r = 0; r < N; r++) begin ax[r] = 0; bx[r] = 0; end
        req_valid = '0; req_a = '0; req_b = '0; en = 1'b0; rst_n = 1'b0;
        repeat (2) step();
        chk("reset_pipe_a",   pipe_a,    0);
        chk("reset_inflight", inflight,  0);
        chk("reset_rsp",      rsp_valid, 0);
        rst_n = 1'b1; en = 1'b1;
        repeat (2) step();

        // Single isolated ops: issue, exit latency, result routing.
        foreach (tbl[i]) begin
            req_valid = '0;
            set_req(tbl[i].r, tbl[i].x, tbl[i].y);
            step();
            req_valid = '0;
            chk("tbl_pipe_a",   pipe_a,   tbl[i].ea);
            chk("tbl_pipe_b",   pipe_b,   tbl[i].eb);
            chk("tbl_inflight", inflight, 1);
            repeat (L) step();
            chk("tbl_rsp_valid", rsp_valid, N'(1) << tbl[i].r);
            chk("tbl_rsp_res",   rsp_res,   tbl[i].eres);
            step();
            chk("tbl_rsp_done",  rsp_valid, 0);
            chk("tbl_idle",      inflight,  0);
        end

        // All four requesting from p=0: grants rotate 0,1,2,3,0,1,...
        do_reset();
        for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < N; r++) set_req(r, $urandom_range(1, 1000), $urandom_range(1, 1000));
            #1;
            chk("rr_order", req_ready, N'(1) << (c % N));
            chk("rr_inflight", inflight, (c <= L + 1) ? c : L + 1);
            step();
        end
        req_valid = '0;
        repeat (L + 2) step();

        // Requesters 0 and 2 only, pointer at 1: order 2,0,2,0.
        set_req(0, 1, 1);
        step();
        for (int c = 0; c < 4; c++) begin
            set_req(0, 1, 1);
            set_req(2, 2, 2);
            #1;
            chk("pair_order", req_ready, (c % 2 == 0) ? 4'b0100 : 4'b0001);
            step();
        end
        req_valid = '0;
        repeat (L + 2) step();

        // Enable dropped with two ops in flight.
        set_req(1, 7, 9);
        step();
        req_valid = '0;
        set_req(2, 30, 12);
        step();
        en = 1'b0;
        for (int r = 0; r < N; r++) set_req(r, r + 1, r + 2);
        repeat (3) begin
            #1;
            chk("en_off_ready", req_ready, 0);
            step();
        end
        step();
        chk("busy_drained", busy, 0);
        en = 1'b1;
        #1;
        chk("resume_ptr", req_ready, 4'b1000);
        step();
        req_valid = '0;
        repeat (L + 2) step();

        // Reset two cycles after three accepts.
        for (int r = 0; r < N; r++) set_req(r, 10 + r, 20 + r);
        repeat (3) step();
        req_valid = '0;
        repeat (2) step();
        do_reset();
        chk("rst_inflight", inflight, 0);
        chk("rst_pipe_a",   pipe_a,   0);
        set_req(1, 4, 4);
        set_req(3, 6, 6);
        #1;
        chk("rst_ptr", req_ready, 4'b0010);
        step();
        req_valid = '0;
        repeat (L + 2) step();

        // Randomized traffic, including enable gaps and occasional resets.
        for (int c = 0; c < 500; c++) begin
            for (int r = 0; r < N; r++) begin
                if ($urandom_range(0, 3) != 0) set_req(r, $urandom_range(1, 1000), $urandom_range(1, 1000));
                else req_valid[NW'(r)] = 1'b0;
            end
            en    = ($urandom_range(0, 7) != 0);
            rst_n = ($urandom_range(0, 63) != 0);
            step();
        end
        rst_n = 1'b1; en = 1'b1; req_valid = '0;
        repeat (L + 3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
